// File: rtl/stream_frame_sched_if.sv
// Request/grant and streamer-control bundle between requesters, the scheduler and the LED streamer.
interface stream_frame_sched_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned CODE_W = 7,
  parameter int unsigned IDX_W  = 13
) ();
  logic [N_REQ-1:0]        req;
  logic [N_REQ*CODE_W-1:0] code_in;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic [CODE_W-1:0]       sel_code;
  logic                    frame_start;
  logic                    bit_tick;
  logic [IDX_W-1:0]        bit_idx;
  logic                    bit_valid;
  logic                    busy;

  modport master (
    output req, code_in,
    input  gnt, done, sel_code, frame_start, bit_tick, bit_idx, bit_valid, busy
  );

  modport slave (
    input  req, code_in,
    output gnt, done, sel_code, frame_start, bit_tick, bit_idx, bit_valid, busy
  );
endinterface

// File: rtl/stream_frame_sched.sv
// Round-robin frame scheduler/sequencer for the serial LED pattern streamer.
// Optional feature: IDLE_REPEAT_EN replays the last frame while no requester is pending.
module stream_frame_sched #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned CODE_W     = 7,
  parameter int unsigned FRAME_BITS = 5132,
  parameter int unsigned PRESCALE   = 655,
  parameter int unsigned GAP_TICKS  = 16,
  parameter int unsigned IDX_W      = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_frame_sched_if.slave bus
);
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PSC_W = $clog2(PRESCALE);
  localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);

  localparam logic [PSC_W-1:0] PSC_MAX   = PSC_W'(PRESCALE - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(FRAME_BITS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, GRANT, SEND, GAP} state_t;

  state_t              r_state;
  logic [PSC_W-1:0]    r_psc;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [IDX_W-1:0]    r_bit_idx;
  logic [PTR_W-1:0]    r_owner;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [CODE_W-1:0]   r_sel_code;
  logic                r_replay;
  logic [N_REQ-1:0]    r_gnt;
  logic [N_REQ-1:0]    r_done;
  logic                r_frame_start;
  logic                r_bit_tick;
  logic                r_bit_valid;
  logic                r_busy;
`ifdef IDLE_REPEAT_EN
  logic                r_sent;
  logic                w_sent_nxt;
`endif

  state_t              w_state_nxt;
  logic [PSC_W-1:0]    w_psc_nxt;
  logic [GAP_W-1:0]    w_gap_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [PTR_W-1:0]    w_owner_nxt;
  logic [PTR_W-1:0]    w_rr_nxt;
  logic [CODE_W-1:0]   w_sel_nxt;
  logic                w_replay_nxt;
  logic [N_REQ-1:0]    w_gnt_nxt;
  logic [N_REQ-1:0]    w_done_nxt;
  logic                w_start_nxt;
  logic                w_tick_nxt;
  logic                w_tick;

  logic [N_REQ-1:0]    w_rot;
  logic [PTR_W-1:0]    w_off;
  logic [PTR_W:0]      w_sum;
  logic [PTR_W-1:0]    w_win;
  logic [PTR_W-1:0]    w_win_inc;
  logic                w_win_vld;
  logic [CODE_W-1:0]   w_win_code;

  // Rotate requests so bit 0 is rr_ptr, pick the lowest set bit, then rotate back.
  always_comb begin
    w_rot     = N_REQ'({bus.req, bus.req} >> r_rr_ptr);
    w_win_vld = |bus.req;
    w_off     = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = PTR_W'(i);
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum > {1'b0, PTR_LAST}) w_sum = w_sum - (PTR_W+1)'(N_REQ);
    w_win      = w_sum[PTR_W-1:0];
    w_win_inc  = (w_win == PTR_LAST) ? '0 : w_win + 1'b1;
    w_win_code = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_win == PTR_W'(i)) w_win_code = bus.code_in[i*CODE_W +: CODE_W];
    end
  end

  assign w_tick = (r_psc == PSC_MAX);

  // Next-state and next-output logic; every registered output is derived from the state being entered.
  always_comb begin
    w_state_nxt  = r_state;
    w_psc_nxt    = r_psc;
    w_gap_nxt    = r_gap_cnt;
    w_idx_nxt    = r_bit_idx;
    w_owner_nxt  = r_owner;
    w_rr_nxt     = r_rr_ptr;
    w_sel_nxt    = r_sel_code;
    w_replay_nxt = r_replay;
    w_done_nxt   = '0;
    w_start_nxt  = 1'b0;
    w_gnt_nxt    = '0;
    w_tick_nxt   = 1'b0;
`ifdef IDLE_REPEAT_EN
    w_sent_nxt   = r_sent;
`endif

    case (r_state)
      IDLE: begin
        w_psc_nxt = '0;
        if (w_win_vld) begin
          w_state_nxt  = GRANT;
          w_owner_nxt  = w_win;
          w_rr_nxt     = w_win_inc;
          w_sel_nxt    = w_win_code;
          w_replay_nxt = 1'b0;
          w_start_nxt  = 1'b1;
          w_idx_nxt    = IDX_FIRST;
`ifdef IDLE_REPEAT_EN
          w_sent_nxt   = 1'b1;
`endif
        end
`ifdef IDLE_REPEAT_EN
        else if (r_sent) begin
          w_state_nxt  = GRANT;
          w_replay_nxt = 1'b1;
          w_start_nxt  = 1'b1;
          w_idx_nxt    = IDX_FIRST;
        end
`endif
      end
      GRANT: begin
        w_state_nxt = SEND;
        w_psc_nxt   = '0;
        w_gap_nxt   = '0;
      end
      SEND: begin
        if (w_tick) begin
          w_psc_nxt = '0;
          if (r_bit_idx == '0) w_state_nxt = GAP;
          else                 w_idx_nxt   = r_bit_idx - 1'b1;
        end else begin
          w_psc_nxt = r_psc + 1'b1;
        end
      end
      GAP: begin
        if (w_tick) begin
          w_psc_nxt = '0;
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nxt = IDLE;
            w_gap_nxt   = '0;
            if (!r_replay) w_done_nxt[r_owner] = 1'b1;
          end else begin
            w_gap_nxt = r_gap_cnt + 1'b1;
          end
        end else begin
          w_psc_nxt = r_psc + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_state_nxt != IDLE && !w_replay_nxt) w_gnt_nxt[w_owner_nxt] = 1'b1;
    w_tick_nxt = (w_state_nxt == SEND || w_state_nxt == GAP) && (w_psc_nxt == PSC_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc         <= '0;
      r_gap_cnt     <= '0;
      r_bit_idx     <= IDX_FIRST;
      r_owner       <= '0;
      r_rr_ptr      <= '0;
      r_sel_code    <= '0;
      r_replay      <= 1'b0;
      r_gnt         <= '0;
      r_done        <= '0;
      r_frame_start <= 1'b0;
      r_bit_tick    <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_busy        <= 1'b0;
`ifdef IDLE_REPEAT_EN
      r_sent        <= 1'b0;
`endif
    end else begin
      r_psc         <= w_psc_nxt;
      r_gap_cnt     <= w_gap_nxt;
      r_bit_idx     <= w_idx_nxt;
      r_owner       <= w_owner_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_sel_code    <= w_sel_nxt;
      r_replay      <= w_replay_nxt;
      r_gnt         <= w_gnt_nxt;
      r_done        <= w_done_nxt;
      r_frame_start <= w_start_nxt;
      r_bit_tick    <= w_tick_nxt;
      r_bit_valid   <= (w_state_nxt == SEND);
      r_busy        <= (w_state_nxt != IDLE);
`ifdef IDLE_REPEAT_EN
      r_sent        <= w_sent_nxt;
`endif
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.done        = r_done;
  assign bus.sel_code    = r_sel_code;
  assign bus.frame_start = r_frame_start;
  assign bus.bit_tick    = r_bit_tick;
  assign bus.bit_idx     = r_bit_idx;
  assign bus.bit_valid   = r_bit_valid;
  assign bus.busy        = r_busy;
endmodule
